// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RV32I
// access-size encodings and the alignment/legality check.
package lsu_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2,
      ST_RESP = 2'd3
   } lsu_state_e;

   localparam logic [2:0] LS_B  = 3'b000;
   localparam logic [2:0] LS_H  = 3'b001;
   localparam logic [2:0] LS_W  = 3'b010;
   localparam logic [2:0] LS_BU = 3'b100;
   localparam logic [2:0] LS_HU = 3'b101;

   // Size/alignment legality only; the address-range check lives in the unit.
   function automatic logic req_fault(input logic       write,
                                      input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
      logic flt;
      case (funct3)
         LS_B:    flt = 1'b0;
         LS_H:    flt = addr_lo[0];
         LS_W:    flt = |addr_lo;
         LS_BU:   flt = write;
         LS_HU:   flt = write | addr_lo[0];
         default: flt = 1'b1;
      endcase
      return flt;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: extracts and extends load data from a memory word, and
// merges sub-word store data into a captured word for read-modify-write.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [2:0]      funct3_i,
   input  logic [1:0]      addr_lo_i,
   input  logic [XLEN-1:0] word_i,
   input  logic [XLEN-1:0] wdata_i,
   output logic [XLEN-1:0] ld_data_c_o,
   output logic [XLEN-1:0] merged_c_o
);

   logic [7:0]  byte_c;
   logic [15:0] half_c;

   always_comb begin
      byte_c      = word_i[{addr_lo_i, 3'b000} +: 8];
      half_c      = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
      ld_data_c_o = '0;
      case (funct3_i)
         LS_B:    ld_data_c_o = {{24{byte_c[7]}}, byte_c};
         LS_H:    ld_data_c_o = {{16{half_c[15]}}, half_c};
         LS_W:    ld_data_c_o = word_i;
         LS_BU:   ld_data_c_o = {24'b0, byte_c};
         LS_HU:   ld_data_c_o = {16'b0, half_c};
         default: ld_data_c_o = '0;
      endcase
   end

   always_comb begin
      merged_c_o = word_i;
      case (funct3_i)
         LS_B:    merged_c_o[{addr_lo_i, 3'b000} +: 8]     = wdata_i[7:0];
         LS_H:    merged_c_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
         default: merged_c_o = wdata_i;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time against a word-wide memory
// with asynchronous read; sub-word stores are done as read-modify-write.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned DMEM_BYTES = 65536
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_write,
   input  logic [2:0]      req_funct3,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   output logic            resp_valid,
   output logic [XLEN-1:0] resp_rdata,
   output logic            resp_fault,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_din,
   output logic            mem_read,
   output logic            mem_write,
   input  logic [XLEN-1:0] mem_dout
);

   lsu_state_e state_q, state_d;

   logic            write_q;
   logic [2:0]      funct3_q;
   logic [1:0]      addr_lo_q;
   logic [XLEN-1:0] wdata_q;

   logic            req_ready_q,  req_ready_d;
   logic            resp_valid_q, resp_valid_d;
   logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
   logic            resp_fault_q, resp_fault_d;
   logic [XLEN-1:0] mem_addr_q,   mem_addr_d;
   logic [XLEN-1:0] mem_din_q,    mem_din_d;
   logic            mem_read_q,   mem_read_d;
   logic            mem_write_q,  mem_write_d;

   logic            accept_c;
   logic            fault_c;
   logic [XLEN-1:0] ld_data_c;
   logic [XLEN-1:0] merged_c;

   assign accept_c = req_valid && (state_q == ST_IDLE);
   assign fault_c  = req_fault(req_write, req_funct3, req_addr[1:0])
                   | (req_addr >= XLEN'(DMEM_BYTES));

   lsu_lane_align u_lane_align (
      .funct3_i    (funct3_q),
      .addr_lo_i   (addr_lo_q),
      .word_i      (mem_dout),
      .wdata_i     (wdata_q),
      .ld_data_c_o (ld_data_c),
      .merged_c_o  (merged_c)
   );

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Word stores skip the read; sub-word stores read first to merge lanes.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               if (fault_c)                               state_d = ST_RESP;
               else if (req_write && req_funct3 == LS_W)  state_d = ST_WR;
               else                                       state_d = ST_RD;
            end
         end
         ST_RD:   state_d = write_q ? ST_WR : ST_RESP;
         ST_WR:   state_d = ST_RESP;
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ready_d  = (state_d == ST_IDLE);
      resp_valid_d = (state_d == ST_RESP);
      mem_read_d   = (state_d == ST_RD);
      mem_write_d  = (state_d == ST_WR);
      mem_addr_d   = mem_addr_q;
      mem_din_d    = mem_din_q;
      resp_rdata_d = resp_rdata_q;
      resp_fault_d = resp_fault_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               mem_addr_d = {req_addr[XLEN-1:2], 2'b00};
               mem_din_d  = req_wdata;
               if (fault_c) begin
                  resp_rdata_d = '0;
                  resp_fault_d = 1'b1;
               end
            end
         end
         ST_RD: begin
            if (write_q) begin
               mem_din_d = merged_c;
            end else begin
               resp_rdata_d = ld_data_c;
               resp_fault_d = 1'b0;
            end
         end
         ST_WR: begin
            resp_rdata_d = '0;
            resp_fault_d = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         write_q   <= 1'b0;
         funct3_q  <= '0;
         addr_lo_q <= '0;
         wdata_q   <= '0;
      end else if (accept_c) begin
         write_q   <= req_write;
         funct3_q  <= req_funct3;
         addr_lo_q <= req_addr[1:0];
         wdata_q   <= req_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_fault_q <= 1'b0;
         mem_addr_q   <= '0;
         mem_din_q    <= '0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
      end else begin
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_fault_q <= resp_fault_d;
         mem_addr_q   <= mem_addr_d;
         mem_din_q    <= mem_din_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_fault = resp_fault_q;
   assign mem_addr   = mem_addr_q;
   assign mem_din    = mem_din_q;
   assign mem_read   = mem_read_q;
   assign mem_write  = mem_write_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, randomized traffic against
// a byte-array reference memory, back-to-back and reset-abort sequences.
module tb_load_store_unit;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_fault;
   logic [31:0] resp_rdata;
   logic [31:0] mem_addr, mem_din, mem_dout;
   logic        mem_read, mem_write;

   always #5 clk = ~clk;

   load_store_unit #(.DMEM_BYTES(65536)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_read(mem_read),
      .mem_write(mem_write), .mem_dout(mem_dout)
   );

   // Data memory (4 KB populated) plus a poke port for initialisation.
   logic [31:0] mem [0:1023];
   logic        poke_en;
   logic [9:0]  poke_idx;
   logic [31:0] poke_val;

   assign mem_dout = mem[mem_addr[11:2]];
   always @(posedge clk) begin
      if (mem_write)    mem[mem_addr[11:2]] <= mem_din;
      else if (poke_en) mem[poke_idx] <= poke_val;
   end

   // Reference model memory, byte addressed.
   logic [7:0] ref_b [0:4095];

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        w;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] rd;
      logic        flt;
      int          lat;
   } vec_t;

   vec_t vt [13];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_word(input logic [31:0] a);
      int b;
      b = int'({a[11:2], 2'b00});
      return {ref_b[b+3], ref_b[b+2], ref_b[b+1], ref_b[b]};
   endfunction

   task automatic poke(input int idx, input logic [31:0] v);
      poke_en  = 1'b1;
      poke_idx = 10'(idx);
      poke_val = v;
      for (int i = 0; i < 4; i++) ref_b[idx*4+i] = v[8*i +: 8];
      @(posedge clk);
      @(negedge clk);
      poke_en = 1'b0;
   endtask

   // Reference behaviour from the RV32I access rules; updates ref_b on stores.
   task automatic ref_apply(input logic w, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, output logic [31:0] rd,
                            output logic flt, output int lat);
      int          n;
      logic        sgn;
      logic [63:0] v;
      flt = 1'b0; sgn = 1'b0; n = 1; rd = '0; v = '0;
      case (f3)
         3'b000:  begin n = 1; sgn = 1'b1; end
         3'b001:  begin n = 2; sgn = 1'b1; end
         3'b010:  n = 4;
         3'b100:  begin n = 1; flt = w; end
         3'b101:  begin n = 2; flt = w; end
         default: flt = 1'b1;
      endcase
      if ((a % n) != 0) flt = 1'b1;
      if (a >= 32'h10000) flt = 1'b1;
      if (flt) begin
         lat = 1;
      end else if (w) begin
         for (int i = 0; i < n; i++) ref_b[a+i] = wd[8*i +: 8];
         lat = (n == 4) ? 2 : 3;
      end else begin
         for (int i = 0; i < n; i++) v = v | (64'(ref_b[a+i]) << (8*i));
         if (sgn && v[8*n-1]) v = v - (64'd1 << (8*n));
         rd  = v[31:0];
         lat = 2;
      end
   endtask

   // Issue one request from IDLE (called at a negedge) and check the response.
   task automatic run_req(input string tag, input logic w, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_flt, input int exp_lat);
      int          lat, nrd, nwr, both, er, ew;
      logic [31:0] hold_rd;
      er = (!exp_flt && (!w || f3 != LS_W)) ? 1 : 0;
      ew = (!exp_flt && w) ? 1 : 0;
      chk({tag, ".ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1; nrd = 0; nwr = 0; both = 0;
      while (resp_valid !== 1'b1 && lat < 8) begin
         nrd += int'(mem_read);
         nwr += int'(mem_write);
         if (mem_read && mem_write) both = 1;
         @(negedge clk);
         lat++;
      end
      chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, ".rdata"}, resp_rdata, exp_rd);
      chk({tag, ".fault"}, 32'(resp_fault), 32'(exp_flt));
      chk({tag, ".reads"}, 32'(nrd), 32'(er));
      chk({tag, ".writes"}, 32'(nwr), 32'(ew));
      chk({tag, ".rd_wr_both"}, 32'(both), 32'd0);
      hold_rd = resp_rdata;
      @(negedge clk);
      chk({tag, ".valid_drop"}, 32'(resp_valid), 32'd0);
      chk({tag, ".rdata_hold"}, resp_rdata, hold_rd);
      chk({tag, ".mem_word"}, mem[a[11:2]], ref_word(a));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] m_rd, a, wd, hold_word;
      logic        m_flt, w;
      logic [2:0]  f3;
      int          m_lat, r, waits, seen;

      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0;
      req_addr = '0; req_wdata = '0; poke_en = 1'b0; poke_idx = '0; poke_val = '0;
      @(negedge clk);
      for (int i = 0; i < 1024; i++) poke(i, $urandom);
      poke(32'h40, 32'h8899AABB);
      reset = 1'b0;
      @(negedge clk);
      chk("rst.ready", 32'(req_ready), 32'd1);
      chk("rst.valid", 32'(resp_valid), 32'd0);
      chk("rst.rdata", resp_rdata, 32'd0);
      chk("rst.fault", 32'(resp_fault), 32'd0);
      chk("rst.mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
      chk("rst.mem_addr", mem_addr, 32'd0);
      chk("rst.mem_din", mem_din, 32'd0);

      // Directed vectors; expected values worked out by hand from the rules.
      vt[0]  = '{1'b0, LS_B,   32'h101,   32'h0,        32'hFFFFFFAA, 1'b0, 2};
      vt[1]  = '{1'b0, LS_BU,  32'h101,   32'h0,        32'h000000AA, 1'b0, 2};
      vt[2]  = '{1'b1, LS_B,   32'h102,   32'h12345677, 32'h0,        1'b0, 3};
      vt[3]  = '{1'b0, LS_W,   32'h100,   32'h0,        32'h8877AABB, 1'b0, 2};
      vt[4]  = '{1'b0, LS_W,   32'h106,   32'h0,        32'h0,        1'b1, 1};
      vt[5]  = '{1'b1, LS_W,   32'h10000, 32'hDEADBEEF, 32'h0,        1'b1, 1};
      vt[6]  = '{1'b0, LS_H,   32'h102,   32'h0,        32'hFFFF8877, 1'b0, 2};
      vt[7]  = '{1'b0, LS_HU,  32'h102,   32'h0,        32'h00008877, 1'b0, 2};
      vt[8]  = '{1'b1, 3'b011, 32'h100,   32'h0,        32'h0,        1'b1, 1};
      vt[9]  = '{1'b1, LS_HU,  32'h100,   32'h0,        32'h0,        1'b1, 1};
      vt[10] = '{1'b0, LS_H,   32'h101,   32'h0,        32'h0,        1'b1, 1};
      vt[11] = '{1'b1, LS_H,   32'h100,   32'hCAFE1234, 32'h0,        1'b0, 3};
      vt[12] = '{1'b0, LS_W,   32'h100,   32'h0,        32'h88771234, 1'b0, 2};
      for (int i = 0; i < 13; i++) begin
         ref_apply(vt[i].w, vt[i].f3, vt[i].a, vt[i].wd, m_rd, m_flt, m_lat);
         run_req($sformatf("vec%0d", i), vt[i].w, vt[i].f3, vt[i].a, vt[i].wd,
                 vt[i].rd, vt[i].flt, vt[i].lat);
      end
      chk("vec.word100", mem[32'h40], 32'h88771234);

      // Back-to-back: SH then LH with req_valid held high throughout.
      ref_apply(1'b1, LS_H, 32'h200, 32'h55559ABC, m_rd, m_flt, m_lat);
      req_valid = 1'b1; req_write = 1'b1; req_funct3 = LS_H;
      req_addr = 32'h200; req_wdata = 32'h55559ABC;
      @(posedge clk);
      @(negedge clk);
      req_write = 1'b0; req_funct3 = LS_H; req_wdata = '0;
      waits = 0; seen = 0;
      while (!req_ready && waits < 10) begin
         seen += int'(resp_valid);
         waits++;
         @(negedge clk);
      end
      chk("b2b.wait", 32'(waits), 32'd3);
      chk("b2b.sh_resp", 32'(seen), 32'd1);
      ref_apply(1'b0, LS_H, 32'h200, 32'h0, m_rd, m_flt, m_lat);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      waits = 1;
      while (resp_valid !== 1'b1 && waits < 8) begin
         @(negedge clk);
         waits++;
      end
      chk("b2b.lh_lat", 32'(waits), 32'd2);
      chk("b2b.lh_rdata", resp_rdata, 32'hFFFF9ABC);
      chk("b2b.model", resp_rdata, m_rd);
      @(negedge clk);

      // Reset while a byte store sits in its read phase: nothing commits.
      hold_word = mem[32'hC0];
      req_valid = 1'b1; req_write = 1'b1; req_funct3 = LS_B;
      req_addr = 32'h301; req_wdata = 32'h000000EE;
      @(posedge clk);
      @(negedge clk);
      chk("rstmid.in_rd", 32'(mem_read), 32'd1);
      reset = 1'b1; req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("rstmid.ready", 32'(req_ready), 32'd1);
      chk("rstmid.mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
      chk("rstmid.mem_din", mem_din, 32'd0);
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         seen += int'(resp_valid) + int'(mem_write);
         @(negedge clk);
      end
      chk("rstmid.no_activity", 32'(seen), 32'd0);
      chk("rstmid.word", mem[32'hC0], hold_word);
      chk("rstmid.ref", mem[32'hC0], ref_word(32'h300));
      ref_apply(1'b0, LS_W, 32'h300, 32'h0, m_rd, m_flt, m_lat);
      run_req("rstmid.after", 1'b0, LS_W, 32'h300, 32'h0, m_rd, m_flt, m_lat);

      // Randomized traffic against the reference model.
      for (int k = 0; k < 150; k++) begin
         r = int'($urandom_range(0, 9));
         case (r)
            0, 1:    f3 = LS_B;
            2, 3:    f3 = LS_H;
            4, 5, 9: f3 = LS_W;
            6:       f3 = LS_BU;
            7:       f3 = LS_HU;
            default: begin
               r  = int'($urandom_range(0, 2));
               f3 = (r == 0) ? 3'b011 : (r == 1) ? 3'b110 : 3'b111;
            end
         endcase
         w = 1'($urandom_range(0, 1));
         r = int'($urandom_range(0, 19));
         if (r == 0)      a = 32'h10000 + ($urandom_range(0, 63) << 2);
         else if (r == 1) a = 32'hFFFFFFFC;
         else begin
            a = 32'h400 + $urandom_range(0, 255);
            if ($urandom_range(0, 3) != 0) begin
               if (f3 == LS_W) a[1:0] = 2'b00;
               else a[0] = 1'b0;
            end
         end
         wd = $urandom;
         ref_apply(w, f3, a, wd, m_rd, m_flt, m_lat);
         run_req($sformatf("rnd%0d", k), w, f3, a, wd, m_rd, m_flt, m_lat);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DMEM_BYTES, default 65536, byte size of data memory; addresses >= DMEM_BYTES are access faults.
REQ-002 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req_valid  input  1  core presents a load/store request.
REQ-005 SHALL have port req_ready  output  1  unit can accept a request this cycle.
REQ-006 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_funct3  input  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata  output  32  extended load result; 0 for stores and faults.
REQ-012 SHALL have port resp_fault  output  1  misaligned, out-of-range or illegal funct3; qualified by resp_valid.
REQ-013 SHALL have ports mem_addr output 32, mem_din output 32, mem_read output 1, mem_write output 1, mem_dout input 32: word-wide data-memory side with asynchronous read, write on clk edge.

Function
REQ-014 SHALL implement FSM states IDLE, RD, WR, RESP; req_ready = 1 only in IDLE.
REQ-015 SHALL accept a request on an edge where req_valid && req_ready, registering write, funct3, addr, wdata.
REQ-016 SHALL fault when H/HU addr[0]!=0, W addr[1:0]!=0, addr >= DMEM_BYTES, or funct3 in {011,110,111} (and 100/101 with req_write=1); faulted requests go IDLE -> RESP with no mem_read/mem_write.
REQ-017 SHALL route loads IDLE -> RD -> RESP; in RD assert mem_read, drive mem_addr = {addr[31:2],2'b00}, capture mem_dout.
REQ-018 SHALL route word stores IDLE -> WR -> RESP; in WR assert mem_write with mem_din = wdata.
REQ-019 SHALL route B/H stores IDLE -> RD -> WR -> RESP (read-modify-write), replacing only the addressed byte lane(s) addr[1:0] in the captured word.
REQ-020 SHALL select load lane by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W pass-through.
REQ-021 SHALL assert resp_valid for exactly the RESP cycle, then return to IDLE; no response back-pressure.
REQ-022 SHALL keep latency accept-edge to resp_valid cycle: load 2, word store 2, sub-word store 3, fault 1 cycles.
REQ-023 SHALL drive mem_read and mem_write 0 outside RD and WR respectively; never both high.
REQ-024 SHALL hold resp_rdata and resp_fault stable from RESP until the next RESP.

Reset
REQ-025 SHALL, with reset high at an edge, enter IDLE and clear resp_valid, resp_fault, resp_rdata, mem_read, mem_write, mem_addr, mem_din to 0.
REQ-026 SHALL abandon any in-flight request on reset mid-operation; a store reset in RD performs no write; a store whose WR edge coincides with reset is not guaranteed to commit.
REQ-027 SHALL present req_ready = 1 the first cycle after reset deasserts.

Structure
REQ-028 SHALL place FSM state encoding and funct3 size constants (LS_B, LS_H, LS_W, LS_BU, LS_HU) in shared package lsu_pkg.
REQ-029 SHALL factor lane extract/extend and lane merge into one combinational sub-module lsu_lane_align; FSM and registers in load_store_unit.

Verification
REQ-030 SHALL cover: mem word 0x100 = 0x8899AABB; load LB addr 0x101 -> resp_rdata 0xFFFFFFAA, resp_valid 2 cycles after accept; LBU same -> 0x000000AA.
REQ-031 SHALL cover: SB wdata 0x12345677 addr 0x102 over 0x8899AABB -> word 0x8877AABB, mem_write exactly one cycle, resp 3 cycles after accept.
REQ-032 SHALL cover: LW addr 0x106 -> resp_fault 1, resp_rdata 0, resp after 1 cycle, mem_read/mem_write never asserted.
REQ-033 SHALL cover: SW addr 0x10000 (DMEM_BYTES default) -> fault, memory unchanged.
REQ-034 SHALL cover: back-to-back req_valid held high for SH 0x200 then LH 0x200 -> second accepted only when req_ready returns, LH returns stored halfword sign-extended.
REQ-035 SHALL cover: reset asserted while SB in RD -> IDLE next cycle, target word unchanged, no resp_valid.
